// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter in front of a single-ported memory.
// Port 0 is the core load/store unit, port 1 is the debug/loader path.
// Grants are issued combinationally from IDLE so a lone request costs no
// extra cycle. Ties go to the port that did not win last time. Writes
// finish in the grant cycle. A read parks the arbiter in WAIT until the
// memory data returns RD_LAT cycles later, then returns that data to the
// requesting port for one cycle.
module mem_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic        i_wren0,
    input  logic        i_wren1,
    input  logic [31:0] i_addr0,
    input  logic [31:0] i_addr1,
    input  logic [31:0] i_wdata0,
    input  logic [31:0] i_wdata1,
    output logic        o_gnt0,
    output logic        o_gnt1,
    output logic        o_rvalid0,
    output logic        o_rvalid1,
    output logic [31:0] o_rdata0,
    output logic [31:0] o_rdata1,
    output logic        o_mem_en,
    output logic        o_mem_wren,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata
);

    // FSM encoding, kept as plain constants for compatibility with older flows
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    // Counter load value. Out-of-range settings are clamped to 1..4 so the
    // 3-bit counter can never be loaded with zero or overflow.
    localparam logic [2:0] LAT_INIT = (RD_LAT < 1) ? 3'd1 :
                                      (RD_LAT > 4) ? 3'd4 : 3'(RD_LAT);

    logic [0:0]  state_r;
    logic [2:0]  cnt_r;
    logic        last_r;      // port that won the most recent grant
    logic        port_r;      // port that owns the outstanding read
    logic [31:0] raddr_r;     // address of the outstanding read

    logic        idle_s;
    logic        fire_s;
    logic        gnt0_s;
    logic        gnt1_s;
    logic        grant_s;
    logic        win_s;
    logic        win_wren_s;
    logic [31:0] win_addr_s;
    logic [31:0] win_wdata_s;

    // While reset is asserted nothing may be granted or driven, even if a
    // requester is already waiting, so reset gates every decision below.
    assign idle_s = i_reset & (state_r == ST_IDLE);
    assign fire_s = i_reset & (state_r == ST_WAIT) & (cnt_r == 3'd1);

    // Arbitration: lone requester wins, ties go to the port not granted last
    always_comb begin
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (idle_s) begin
            case ({i_req1, i_req0})
                2'b01: gnt0_s = 1'b1;
                2'b10: gnt1_s = 1'b1;
                2'b11: begin
                    if (last_r) begin
                        gnt0_s = 1'b1;
                    end else begin
                        gnt1_s = 1'b1;
                    end
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end else begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end
    end

    // Winner select: route the granted port's command fields
    always_comb begin
        grant_s     = gnt0_s | gnt1_s;
        win_s       = gnt1_s;
        win_wren_s  = 1'b0;
        win_addr_s  = 32'h0000_0000;
        win_wdata_s = 32'h0000_0000;
        if (gnt1_s) begin
            win_wren_s  = i_wren1;
            win_addr_s  = i_addr1;
            win_wdata_s = i_wdata1;
        end else begin
            win_wren_s  = i_wren0;
            win_addr_s  = i_addr0;
            win_wdata_s = i_wdata0;
        end
    end

    // Memory command: winner's access on a grant, held read address in WAIT
    always_comb begin
        o_mem_en    = 1'b0;
        o_mem_wren  = 1'b0;
        o_mem_addr  = 32'h0000_0000;
        o_mem_wdata = 32'h0000_0000;
        if (grant_s) begin
            o_mem_en    = 1'b1;
            o_mem_wren  = win_wren_s;
            o_mem_addr  = win_addr_s;
            o_mem_wdata = win_wdata_s;
        end else if (i_reset && (state_r == ST_WAIT)) begin
            o_mem_addr  = raddr_r;
        end else begin
            o_mem_en    = 1'b0;
            o_mem_wren  = 1'b0;
            o_mem_addr  = 32'h0000_0000;
            o_mem_wdata = 32'h0000_0000;
        end
    end

    // Grant outputs
    always_comb begin
        o_gnt0 = gnt0_s;
        o_gnt1 = gnt1_s;
    end

    // Read return: one-cycle valid to the owning port, data forced to zero otherwise
    always_comb begin
        o_rvalid0 = fire_s & ~port_r;
        o_rvalid1 = fire_s & port_r;
        if (o_rvalid0) begin
            o_rdata0 = i_mem_rdata;
        end else begin
            o_rdata0 = 32'h0000_0000;
        end
        if (o_rvalid1) begin
            o_rdata1 = i_mem_rdata;
        end else begin
            o_rdata1 = 32'h0000_0000;
        end
    end

    // Control state: FSM, latency counter, round-robin pointer, read owner
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
            last_r  <= 1'b1;
            port_r  <= 1'b0;
            raddr_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_s) begin
                        last_r <= win_s;
                        if (!win_wren_s) begin
                            state_r <= ST_WAIT;
                            cnt_r   <= LAT_INIT;
                            port_r  <= win_s;
                            raddr_r <= win_addr_s;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == 3'd1) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 3'd0;
                    end else begin
                        cnt_r   <= cnt_r - 3'd1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= 3'd0;
                end
            endcase
        end
    end

endmodule
